// File: rtl/sdf_pkg.sv
`default_nettype none
// sdf_pkg: state encoding, word-width helper and saturation for the radix-2 SDF FFT stage. Rev 1.0
package sdf_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    BFLY  = 2'd1,
    DRAIN = 2'd2
  } sdf_state_t;

  // Working width for saturation; OW + TW + 1 must not exceed this.
  localparam int SAT_W = 64;

  // Stage output words carry one growth bit over the input.
  function automatic int calc_ow(input int dw);
    return dw + 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_to(input logic signed [SAT_W-1:0] x,
                                                     input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdf_r2_stage_if.sv
`default_nettype none
// sdf_r2_stage_if: sample, twiddle-ROM and result bundle of one SDF FFT stage. Rev 1.0
interface sdf_r2_stage_if
  import sdf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 22,
  parameter int TW    = 16
);
  localparam int OW = calc_ow(DW);
  localparam int IW = $clog2(DEPTH);

  logic                 in_valid;
  logic                 flush;
  logic signed [DW-1:0] din_real;
  logic signed [DW-1:0] din_imag;
  logic signed [TW-1:0] tw_real;
  logic signed [TW-1:0] tw_imag;
  logic [IW-1:0]        tw_idx;
  logic                 busy;
  logic                 out_valid;
  logic                 out_first;
  logic signed [OW-1:0] dout_real;
  logic signed [OW-1:0] dout_imag;

  modport master (
    output in_valid, flush, din_real, din_imag, tw_real, tw_imag,
    input  tw_idx, busy, out_valid, out_first, dout_real, dout_imag
  );

  modport slave (
    input  in_valid, flush, din_real, din_imag, tw_real, tw_imag,
    output tw_idx, busy, out_valid, out_first, dout_real, dout_imag
  );

endinterface
`default_nettype wire

// File: rtl/sdf_cmul.sv
`default_nettype none
// sdf_cmul: combinational complex multiply, scale by 2^-TW_FRAC, saturate to OW. Rev 1.0
// SDF_ROUND_EN selects round-half-up; otherwise the shift truncates toward -inf.
module sdf_cmul
  import sdf_pkg::*;
#(
  parameter int OW      = 23,
  parameter int TW      = 16,
  parameter int TW_FRAC = 14
) (
  input  wire logic signed [OW-1:0] a_re,
  input  wire logic signed [OW-1:0] a_im,
  input  wire logic signed [TW-1:0] w_re,
  input  wire logic signed [TW-1:0] w_im,
  output logic signed [OW-1:0]      p_re,
  output logic signed [OW-1:0]      p_im
);

  // One bit above the product width absorbs the add/sub of two products.
  localparam int PW = OW + TW + 1;

`ifdef SDF_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(2 ** (TW_FRAC - 1));
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif

  logic signed [PW-1:0] ar;
  logic signed [PW-1:0] ai;
  logic signed [PW-1:0] wr;
  logic signed [PW-1:0] wi;
  logic signed [PW-1:0] acc_re;
  logic signed [PW-1:0] acc_im;
  logic signed [PW-1:0] sh_re;
  logic signed [PW-1:0] sh_im;

  assign ar = PW'(a_re);
  assign ai = PW'(a_im);
  assign wr = PW'(w_re);
  assign wi = PW'(w_im);

  assign acc_re = ar * wr - ai * wi + RND;
  assign acc_im = ar * wi + ai * wr + RND;

  assign sh_re = acc_re >>> TW_FRAC;
  assign sh_im = acc_im >>> TW_FRAC;

  assign p_re = OW'(sat_to(SAT_W'(sh_re), OW));
  assign p_im = OW'(sat_to(SAT_W'(sh_im), OW));

endmodule
`default_nettype wire

// File: rtl/sdf_r2_stage.sv
`default_nettype none
// sdf_r2_stage: radix-2 DIF single-path-delay-feedback FFT stage with internal delay line. Rev 1.0
// Build option SDF_ROUND_EN: round-half-up in the twiddle multiply (default truncation).
module sdf_r2_stage
  import sdf_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DW      = 22,
  parameter int TW      = 16,
  parameter int TW_FRAC = 14
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  sdf_r2_stage_if.slave bus
);

  localparam int OW = calc_ow(DW);
  localparam int CW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  sdf_state_t state;
  sdf_state_t state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic pend;
  logic pend_nx;

  logic signed [OW-1:0] dl_re [DEPTH];
  logic signed [OW-1:0] dl_im [DEPTH];

  logic                 advance;
  logic                 emit;
  logic                 emit_first;
  logic signed [OW-1:0] push_re;
  logic signed [OW-1:0] push_im;
  logic signed [OW-1:0] res_re;
  logic signed [OW-1:0] res_im;
  logic signed [OW-1:0] din_re_x;
  logic signed [OW-1:0] din_im_x;
  logic signed [OW-1:0] mul_re;
  logic signed [OW-1:0] mul_im;

  logic                 out_valid_r;
  logic                 out_first_r;
  logic signed [OW-1:0] dout_re_r;
  logic signed [OW-1:0] dout_im_r;

  assign din_re_x = {bus.din_real[DW-1], bus.din_real};
  assign din_im_x = {bus.din_imag[DW-1], bus.din_imag};

  sdf_cmul #(
    .OW      (OW),
    .TW      (TW),
    .TW_FRAC (TW_FRAC)
  ) u_cmul (
    .a_re (dl_re[0]),
    .a_im (dl_im[0]),
    .w_re (bus.tw_real),
    .w_im (bus.tw_imag),
    .p_re (mul_re),
    .p_im (mul_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pend  <= pend_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pend_nx    = pend;
    advance    = 1'b0;
    emit       = 1'b0;
    emit_first = 1'b0;
    push_re    = '0;
    push_im    = '0;
    res_re     = '0;
    res_im     = '0;
    case (state)
      FILL: begin
        // in_valid wins over flush: a new frame drains the pending half itself.
        if (bus.in_valid) begin
          advance = 1'b1;
          push_re = din_re_x;
          push_im = din_im_x;
          if (pend) begin
            emit   = 1'b1;
            res_re = mul_re;
            res_im = mul_im;
          end
          cnt_nx = cnt + CW'(1);
          if (cnt == LAST) state_nx = BFLY;
        end else if (bus.flush && pend && (cnt == '0)) begin
          state_nx = DRAIN;
        end
      end
      BFLY: begin
        if (bus.in_valid) begin
          advance    = 1'b1;
          emit       = 1'b1;
          emit_first = (cnt == '0);
          res_re     = dl_re[0] + din_re_x;
          res_im     = dl_im[0] + din_im_x;
          push_re    = dl_re[0] - din_re_x;
          push_im    = dl_im[0] - din_im_x;
          cnt_nx     = cnt + CW'(1);
          if (cnt == LAST) begin
            state_nx = FILL;
            pend_nx  = 1'b1;
          end
        end
      end
      DRAIN: begin
        advance = 1'b1;
        emit    = 1'b1;
        res_re  = mul_re;
        res_im  = mul_im;
        cnt_nx  = cnt + CW'(1);
        if (cnt == LAST) begin
          state_nx = FILL;
          pend_nx  = 1'b0;
        end
      end
      default: begin
        state_nx = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        dl_re[i] <= '0;
        dl_im[i] <= '0;
      end
      out_valid_r <= 1'b0;
      out_first_r <= 1'b0;
      dout_re_r   <= '0;
      dout_im_r   <= '0;
    end else begin
      if (advance) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          dl_re[i] <= dl_re[i+1];
          dl_im[i] <= dl_im[i+1];
        end
        dl_re[DEPTH-1] <= push_re;
        dl_im[DEPTH-1] <= push_im;
      end
      out_valid_r <= emit;
      out_first_r <= emit_first;
      if (emit) begin
        dout_re_r <= res_re;
        dout_im_r <= res_im;
      end
    end
  end

  assign bus.tw_idx    = (state == BFLY) ? '0 : cnt;
  assign bus.busy      = (state == DRAIN);
  assign bus.out_valid = out_valid_r;
  assign bus.out_first = out_first_r;
  assign bus.dout_real = dout_re_r;
  assign bus.dout_imag = dout_im_r;

endmodule
`default_nettype wire

// File: tb/tb_sdf_r2_stage.sv
`default_nettype none
// tb_sdf_r2_stage: directed self-checking bench for sdf_r2_stage at DEPTH=4, DW=8. Rev 1.0
module tb_sdf_r2_stage;

  localparam int DEPTH   = 4;
  localparam int DW      = 8;
  localparam int TW      = 16;
  localparam int TW_FRAC = 14;
  localparam int OW      = DW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdf_r2_stage_if #(.DEPTH(DEPTH), .DW(DW), .TW(TW)) bus ();

  sdf_r2_stage #(.DEPTH(DEPTH), .DW(DW), .TW(TW), .TW_FRAC(TW_FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic signed [TW-1:0] rom_re [DEPTH];
  logic signed [TW-1:0] rom_im [DEPTH];
  assign bus.tw_real = rom_re[bus.tw_idx];
  assign bus.tw_imag = rom_im[bus.tw_idx];

  int checks = 0;
  int passed = 0;

  logic signed [OW-1:0] q_re [$];
  logic signed [OW-1:0] q_im [$];
  logic                 q_first [$];
  logic                 qv [$];
  logic                 qb [$];
  logic [1:0]           qi [$];

  task automatic clear_q();
    q_re.delete(); q_im.delete(); q_first.delete();
    qv.delete(); qb.delete(); qi.delete();
  endtask

  task automatic set_rom(input int re, input int im);
    for (int i = 0; i < DEPTH; i++) begin
      rom_re[i] = TW'(re);
      rom_im[i] = TW'(im);
    end
  endtask

  // One clock: drive inputs, note busy/tw_idx before the edge, capture outputs after it.
  task automatic cyc(input logic v, input logic f, input int re, input int im);
    bus.in_valid = v;
    bus.flush    = f;
    bus.din_real = DW'(re);
    bus.din_imag = DW'(im);
    #2;
    qb.push_back(bus.busy);
    qi.push_back(bus.tw_idx);
    @(posedge clk);
    #1;
    qv.push_back(bus.out_valid);
    if (bus.out_valid) begin
      q_re.push_back(bus.dout_real);
      q_im.push_back(bus.dout_imag);
      q_first.push_back(bus.out_first);
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.din_real = '0;
    bus.din_imag = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_q();
  endtask

  task automatic test_reset();
    int e[4] = '{6, 7, 8, 9};
    do_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", bus.out_valid); else passed++;
    checks++; if (bus.dout_real !== '0) $display("FAIL rst_dout_re: got %0d want 0", bus.dout_real); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", bus.busy); else passed++;
    rst_n = 1'b1;
    set_rom(16384, 0);
    cyc(1, 0, 10, 0); cyc(1, 0, 20, 0); cyc(1, 0, 30, 0); cyc(1, 0, 40, 0);
    cyc(1, 0, 1, 0);  cyc(1, 0, 2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL arst_valid: got %0b want 0", bus.out_valid); else passed++;
    checks++; if (bus.dout_real !== '0 || bus.dout_imag !== '0) $display("FAIL arst_dout: got %0d/%0d want 0/0", bus.dout_real, bus.dout_imag); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL arst_busy: got %0b want 0", bus.busy); else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_q();
    cyc(1, 0, 5, 0); cyc(1, 0, 6, 0); cyc(1, 0, 7, 0); cyc(1, 0, 8, 0);
    checks++; if (q_re.size() != 0) $display("FAIL arst_stale: got %0d outputs want 0", q_re.size()); else passed++;
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0);
    checks++; if (q_re.size() != 4) $display("FAIL arst_cnt: got %0d want 4", q_re.size()); else passed++;
    for (int i = 0; i < 4 && i < q_re.size(); i++) begin
      checks++; if (q_re[i] !== OW'(e[i])) $display("FAIL arst_sum[%0d]: got %0d want %0d", i, q_re[i], e[i]); else passed++;
    end
  endtask

  task automatic test_w1();
    int e[4] = '{4, 6, 8, 10};
    int eb[6] = '{0, 1, 1, 1, 1, 0};
    do_reset();
    set_rom(16384, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, i, 0);
    checks++; if (q_re.size() != 4) $display("FAIL w1_sum_cnt: got %0d want 4", q_re.size()); else passed++;
    for (int i = 0; i < 4 && i < q_re.size(); i++) begin
      checks++; if (q_re[i] !== OW'(e[i]) || q_im[i] !== '0) $display("FAIL w1_sum[%0d]: got %0d/%0d want %0d/0", i, q_re[i], q_im[i], e[i]); else passed++;
      checks++; if (q_first[i] !== (i == 0)) $display("FAIL w1_first[%0d]: got %0b want %0b", i, q_first[i], (i == 0)); else passed++;
    end
    clear_q();
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      checks++; if (qb[i] !== eb[i][0]) $display("FAIL w1_busy[%0d]: got %0b want %0d", i, qb[i], eb[i]); else passed++;
    end
    for (int i = 1; i < 5; i++) begin
      checks++; if (qi[i] !== 2'(i - 1)) $display("FAIL w1_twidx[%0d]: got %0d want %0d", i, qi[i], i - 1); else passed++;
    end
    checks++; if (q_re.size() != 4) $display("FAIL w1_drain_cnt: got %0d want 4", q_re.size()); else passed++;
    for (int i = 0; i < 4 && i < q_re.size(); i++) begin
      checks++; if (q_re[i] !== -9'sd4 || q_im[i] !== '0) $display("FAIL w1_drain[%0d]: got %0d/%0d want -4/0", i, q_re[i], q_im[i]); else passed++;
    end
  endtask

  task automatic test_wmj();
    do_reset();
    set_rom(0, -16384);
    for (int i = 0; i < 8; i++) cyc(1, 0, i, 0);
    clear_q();
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    checks++; if (q_re.size() != 4) $display("FAIL wmj_cnt: got %0d want 4", q_re.size()); else passed++;
    for (int i = 0; i < 4 && i < q_re.size(); i++) begin
      checks++; if (q_re[i] !== '0 || q_im[i] !== 9'sd4) $display("FAIL wmj_drain[%0d]: got %0d/%0d want 0/4", i, q_re[i], q_im[i]); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int din[16] = '{10, 20, 30, 40, 1, 2, 3, 4, -5, -6, -7, -8, 1, 1, 1, 1};
    int e[12]   = '{11, 22, 33, 44, 9, 18, 27, 36, -4, -5, -6, -7};
    int ed[4]   = '{-6, -7, -8, -9};
    int bad;
    do_reset();
    set_rom(16384, 0);
    // flush together with in_valid at the frame-2 start must lose to in_valid
    for (int i = 0; i < 16; i++) cyc(1, (i == 8), din[i], -din[i]);
    bad = 0;
    for (int i = 0; i < 16; i++) if (qv[i] !== (i >= 4)) bad++;
    checks++; if (bad != 0) $display("FAIL b2b_valid_gaps: got %0d bad cycles want 0", bad); else passed++;
    checks++; if (q_re.size() != 12) $display("FAIL b2b_cnt: got %0d want 12", q_re.size()); else passed++;
    for (int i = 0; i < 12 && i < q_re.size(); i++) begin
      checks++; if (q_re[i] !== OW'(e[i]) || q_im[i] !== OW'(-e[i])) $display("FAIL b2b_out[%0d]: got %0d/%0d want %0d/%0d", i, q_re[i], q_im[i], e[i], -e[i]); else passed++;
      checks++; if (q_first[i] !== (i == 0 || i == 8)) $display("FAIL b2b_first[%0d]: got %0b want %0b", i, q_first[i], (i == 0 || i == 8)); else passed++;
    end
    clear_q();
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    checks++; if (q_re.size() != 4) $display("FAIL b2b_drain_cnt: got %0d want 4", q_re.size()); else passed++;
    for (int i = 0; i < 4 && i < q_re.size(); i++) begin
      checks++; if (q_re[i] !== OW'(ed[i]) || q_im[i] !== OW'(-ed[i])) $display("FAIL b2b_drain[%0d]: got %0d/%0d want %0d/%0d", i, q_re[i], q_im[i], ed[i], -ed[i]); else passed++;
    end
  endtask

  task automatic test_sat_round();
    int fre[8] = '{127, -128, 1, 0, -128, 127, 0, 1};
    int fim[8] = '{127, -128, 0, 0, -128, 127, 0, 0};
`ifdef SDF_ROUND_EN
    int ere[4] = '{0, 0, 1, 0};
`else
    int ere[4] = '{0, 0, 0, -1};
`endif
    int eim[4] = '{255, -256, 0, 0};
    do_reset();
    rom_re[0] = 16'sd16384; rom_im[0] = 16'sd16384;
    rom_re[1] = 16'sd16384; rom_im[1] = 16'sd16384;
    rom_re[2] = 16'sd8192;  rom_im[2] = 16'sd0;
    rom_re[3] = 16'sd8192;  rom_im[3] = 16'sd0;
    for (int i = 0; i < 8; i++) cyc(1, 0, fre[i], fim[i]);
    clear_q();
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    checks++; if (q_re.size() != 4) $display("FAIL satr_cnt: got %0d want 4", q_re.size()); else passed++;
    for (int i = 0; i < 4 && i < q_re.size(); i++) begin
      checks++; if (q_re[i] !== OW'(ere[i]) || q_im[i] !== OW'(eim[i])) $display("FAIL satr_out[%0d]: got %0d/%0d want %0d/%0d", i, q_re[i], q_im[i], ere[i], eim[i]); else passed++;
    end
    do_reset();
    set_rom(16384, 16384);
    for (int i = 0; i < 8; i++) cyc(1, 0, (i < 4) ? 127 : -128, 0);
    clear_q();
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    checks++; if (q_re.size() != 4) $display("FAIL sat255_cnt: got %0d want 4", q_re.size()); else passed++;
    for (int i = 0; i < 4 && i < q_re.size(); i++) begin
      checks++; if (q_re[i] !== 9'sd255 || q_im[i] !== 9'sd255) $display("FAIL sat255_out[%0d]: got %0d/%0d want 255/255", i, q_re[i], q_im[i]); else passed++;
    end
  endtask

  task automatic test_stall_flush();
    int es[4]  = '{11, 22, 33, 44};
    int ev[7]  = '{1, 0, 1, 0, 0, 1, 1};
    int eb[8]  = '{9, 18, 27, 36, -4, -5, -6, -7};
    int ed[4]  = '{-6, -7, -8, -9};
    int ec[4]  = '{3, 5, 7, 9};
    int bad;
    do_reset();
    set_rom(16384, 0);
    cyc(1, 0, 10, 0); cyc(1, 0, 20, 0); cyc(1, 0, 30, 0); cyc(1, 0, 40, 0);
    clear_q();
    cyc(1, 0, 1, 0); cyc(0, 0, 99, 0); cyc(1, 0, 2, 0); cyc(0, 1, 99, 0);
    cyc(0, 0, 99, 0); cyc(1, 0, 3, 0); cyc(1, 0, 4, 0);
    bad = 0;
    for (int i = 0; i < 7; i++) if (qv[i] !== ev[i][0]) bad++;
    checks++; if (bad != 0) $display("FAIL stall_valid: got %0d bad cycles want 0", bad); else passed++;
    checks++; if (q_re.size() != 4) $display("FAIL stall_cnt: got %0d want 4", q_re.size()); else passed++;
    for (int i = 0; i < 4 && i < q_re.size(); i++) begin
      checks++; if (q_re[i] !== OW'(es[i])) $display("FAIL stall_sum[%0d]: got %0d want %0d", i, q_re[i], es[i]); else passed++;
    end
    clear_q();
    cyc(1, 0, -5, 0); cyc(1, 0, -6, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, -7, 0); cyc(1, 0, -8, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0);
    bad = 0;
    foreach (qb[i]) if (qb[i] !== 1'b0) bad++;
    checks++; if (bad != 0) $display("FAIL flush_ignored_busy: got %0d busy cycles want 0", bad); else passed++;
    checks++; if (q_re.size() != 8) $display("FAIL flush_ignored_cnt: got %0d want 8", q_re.size()); else passed++;
    for (int i = 0; i < 8 && i < q_re.size(); i++) begin
      checks++; if (q_re[i] !== OW'(eb[i])) $display("FAIL flush_ignored_out[%0d]: got %0d want %0d", i, q_re[i], eb[i]); else passed++;
    end
    clear_q();
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 99, 0);
    checks++; if (q_re.size() != 4) $display("FAIL drain_drop_cnt: got %0d want 4", q_re.size()); else passed++;
    for (int i = 0; i < 4 && i < q_re.size(); i++) begin
      checks++; if (q_re[i] !== OW'(ed[i])) $display("FAIL drain_drop_out[%0d]: got %0d want %0d", i, q_re[i], ed[i]); else passed++;
    end
    clear_q();
    cyc(1, 0, 2, 0); cyc(1, 0, 4, 0); cyc(1, 0, 6, 0); cyc(1, 0, 8, 0);
    checks++; if (q_re.size() != 0) $display("FAIL post_drain_fill: got %0d outputs want 0", q_re.size()); else passed++;
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0);
    checks++; if (q_re.size() != 4) $display("FAIL post_drain_cnt: got %0d want 4", q_re.size()); else passed++;
    for (int i = 0; i < 4 && i < q_re.size(); i++) begin
      checks++; if (q_re[i] !== OW'(ec[i])) $display("FAIL post_drain_sum[%0d]: got %0d want %0d", i, q_re[i], ec[i]); else passed++;
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.din_real = '0;
    bus.din_imag = '0;
    set_rom(16384, 0);
    test_reset();
    test_w1();
    test_wmj();
    test_back_to_back();
    test_sat_round();
    test_stall_flush();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
